// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared types, constants and helpers for the mux select sequencer
package mux_sel_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

    function automatic logic [1:0] onehot_to_sel(input logic [NUM_CH-1:0] oh);
        logic [1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) sel = 2'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux_select_sequencer_pick.sv
// rtl/mux_select_sequencer_pick.sv - circular priority pick of the next requester after last
module rr_priority_pick
    import mux_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        last,
    output logic              any,
    output logic [1:0]        pick
);

    // Scan from lowest to highest priority so the nearest channel after last wins.
    always_comb begin
        any  = |req;
        pick = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[last + 2'(i)]) pick = last + 2'(i);
        end
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - round-robin dwell-timed select generator for a 4:1 mux
module mux_select_sequencer
    import mux_sel_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    output logic              s1,
    output logic              s0,
    output logic [NUM_CH-1:0] gnt,
    output logic              sel_valid,
    output logic              switch_p
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        sel_q, sel_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              sel_valid_q, sel_valid_d;
    logic              switch_p_q, switch_p_d;

    logic [1:0]        cur;
    logic [1:0]        pick_from;
    logic              any;
    logic [1:0]        pick;

    assign cur       = onehot_to_sel(gnt_q);
    // While holding, the current channel is the round-robin reference point.
    assign pick_from = (state_q == HOLD) ? cur : last_q;

    rr_priority_pick u_pick (
        .req  (req),
        .last (pick_from),
        .any  (any),
        .pick (pick)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        sel_valid_d = sel_valid_q;
        switch_p_d  = 1'b0;

        if (!en || (state_q == HOLD && (cnt_q == '0 || !req[cur]) && !any)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sel_d       = '0;
            gnt_d       = '0;
            sel_valid_d = 1'b0;
        end else if ((state_q == IDLE && any) ||
                     (state_q == HOLD && (cnt_q == '0 || !req[cur]))) begin
            state_d     = HOLD;
            cnt_d       = RELOAD;
            last_d      = pick;
            sel_d       = pick;
            gnt_d       = NUM_CH'(1) << pick;
            sel_valid_d = 1'b1;
            switch_p_d  = (state_q == IDLE) || (pick != cur);
        end else if (state_q == HOLD) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 2'd3;
            sel_q       <= '0;
            gnt_q       <= '0;
            sel_valid_q <= 1'b0;
            switch_p_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            sel_valid_q <= sel_valid_d;
            switch_p_q  <= switch_p_d;
        end
    end

    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign gnt       = gnt_q;
    assign sel_valid = sel_valid_q;
    assign switch_p  = switch_p_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - scoreboard bench with a round-robin reference model and mux model
module tb_mux_select_sequencer;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'b1111;
    logic       s1, s0, sel_valid, switch_p;
    logic [3:0] gnt;

    logic [7:0] din [4];
    logic [7:0] w;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb [$];

    bit m_active;
    int m_cur, m_last, m_held;

    mux_select_sequencer #(.DWELL(DWELL), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .s1        (s1),
        .s0        (s0),
        .gnt       (gnt),
        .sel_valid (sel_valid),
        .switch_p  (switch_p)
    );

    always #5 clk = ~clk;

    assign w = din[{s1, s0}];

    function automatic int next_after(int from, logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return from;
    endfunction

    initial begin
        m_active = 0;
        m_last   = 3;
        m_cur    = 0;
        m_held   = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0;
                m_last   = 3;
                m_cur    = 0;
                m_held   = 0;
            end else begin : model_step
                bit sw;
                int n;
                logic [7:0] vec;
                sw = 0;
                if (!en) begin
                    m_active = 0;
                end else if (!m_active) begin
                    if (req != 4'b0) begin
                        m_cur    = next_after(m_last, req);
                        m_last   = m_cur;
                        m_active = 1;
                        m_held   = 1;
                        sw       = 1;
                    end
                end else if (m_held == DWELL || !req[m_cur]) begin
                    if (req == 4'b0) begin
                        m_active = 0;
                    end else begin
                        n      = next_after(m_cur, req);
                        sw     = (n != m_cur);
                        m_cur  = n;
                        m_last = n;
                        m_held = 1;
                    end
                end else begin
                    m_held++;
                end
                if (m_active) vec = {2'(m_cur), 4'(1 << m_cur), 1'b1, sw};
                else          vec = 8'b0;
                sb.push_back({2'(m_cur), vec});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin : monitor_step
                logic [9:0] e;
                logic [7:0] got;
                logic [1:0] ecur;
                e    = sb.pop_front();
                ecur = e[9:8];
                got  = {s1, s0, gnt, sel_valid, switch_p};
                checks++;
                if (got !== e[7:0]) begin
                    errors++;
                    $display("FAIL outputs t=%0t got {s1,s0,gnt,vld,sw}=%b expected=%b", $time, got, e[7:0]);
                end
                if (e[1]) begin
                    checks++;
                    if (w !== din[ecur]) begin
                        errors++;
                        $display("FAIL mux_w t=%0t got=%h expected=%h (ch%0d)", $time, w, din[ecur], ecur);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({s1, s0, gnt, sel_valid, switch_p} !== 8'b0) begin
            errors++;
            $display("FAIL %s got {s1,s0,gnt,vld,sw}=%b expected=00000000", name,
                     {s1, s0, gnt, sel_valid, switch_p});
        end
    endtask

    task automatic cycle(input logic e, input logic [3:0] r);
        @(negedge clk);
        #2;
        en  = e;
        req = r;
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        en  = 1'b0;
        req = 4'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        en  = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_reset_outputs("reset_hold");
        end
        #1;
        en    = 1'b0;
        req   = 4'b0;
        rst_n = 1'b1;

        // single requester: grant persists without further switch pulses
        for (int i = 0; i < 12; i++) cycle(1'b1, 4'b0100);

        reset_pulse();
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'b1111);

        // early drop of the granted request
        reset_pulse();
        cycle(1'b1, 4'b0010);
        cycle(1'b1, 4'b0010);
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'b1001);

        // enable dropped mid-hold, last channel retained
        reset_pulse();
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0100);
        cycle(1'b0, 4'b0100);
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'b1111);

        // async reset mid-grant restarts priority at channel 0
        reset_pulse();
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1000);
        reset_pulse();
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'b1111);

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 79) == 0) reset_pulse();
            else cycle(($urandom_range(0, 15) != 0), 4'($urandom));
        end

        cycle(1'b0, 4'b0);
        cycle(1'b0, 4'b0);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
